// File: rtl/indication_beat_deserializer.sv
// indication_beat_deserializer: assembles header+payload beats into one packed message; optional INDICATION_DESER_ERRCNT_EN adds excess-word error counters
module indication_beat_deserializer #(
  parameter int DATA_WIDTH = 32,
  parameter int SLOTS = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        beat_enq_ena,
  input  logic [DATA_WIDTH-1:0]       beat_enq_v,
  output logic                        beat_enq_rdy,
  output logic                        pipe_enq_ena,
  output logic [SLOTS*DATA_WIDTH-1:0] pipe_enq_v,
  input  logic                        pipe_enq_rdy
`ifdef INDICATION_DESER_ERRCNT_EN
  ,
  output logic [15:0]                 err_count,
  output logic                        err_flag
`endif
);
  localparam int IW = $clog2(SLOTS + 1);
  typedef enum logic [1:0] {HDR, PAY, SEND} state_t;
  state_t state, state_nxt;
  logic [SLOTS*DATA_WIDTH-1:0] msg;
  logic [15:0] rem;
  logic [IW-1:0] idx;
  logic acc, drop;
  assign acc  = beat_enq_ena && beat_enq_rdy;
  assign drop = acc && state == PAY && idx == IW'(SLOTS);
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= HDR;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (state == HDR && acc) state_nxt = beat_enq_v[31:16] == 16'd0 ? SEND : PAY;
    if (state == PAY && acc && rem == 16'd1) state_nxt = SEND;
    if (state == SEND && pipe_enq_rdy) state_nxt = HDR;
  end
  always_comb begin
    beat_enq_rdy = state != SEND;
    pipe_enq_ena = state == SEND && pipe_enq_rdy;
    pipe_enq_v   = msg;
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      msg <= '0;
      rem <= '0;
      idx <= '0;
    end else if (acc && state == HDR) begin
      msg <= '0;
      msg[DATA_WIDTH-1:0] <= {{(DATA_WIDTH-16){1'b0}}, beat_enq_v[15:0]};
      idx <= IW'(1);
      rem <= beat_enq_v[31:16];
    end else if (acc && state == PAY) begin
      for (int s = 1; s < SLOTS; s++)
        if (idx == IW'(s)) msg[s*DATA_WIDTH +: DATA_WIDTH] <= beat_enq_v;
      idx <= idx == IW'(SLOTS) ? idx : idx + 1'b1;
      rem <= rem - 16'd1;
    end
`ifdef INDICATION_DESER_ERRCNT_EN
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      err_count <= '0;
      err_flag  <= 1'b0;
    end else if (drop) begin
      err_count <= err_count == 16'hFFFF ? err_count : err_count + 16'd1;
      err_flag  <= 1'b1;
    end
`endif
endmodule
